// File: rtl/sdram_arbiter_pkg.sv
// Shared types and default widths for the two-port SDRAM burst arbiter.
package sdram_arbiter_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 9;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REQ,
        S_BURST,
        S_DONE,
        S_WAIT
    } state_t;

    // A zero-length request still moves one word.
    function automatic logic [LEN_W-1:0] fix_len(input logic [LEN_W-1:0] l);
        return (l == '0) ? LEN_W'(1) : l;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and sdram_top-side signal bundle of the burst arbiter.
interface sdram_arbiter_if;
    import sdram_arbiter_pkg::*;

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [LEN_W-1:0]  p0_len;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_done;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [LEN_W-1:0]  p1_len;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_done;

    logic              sdram_init_done;
    logic              sdram_busy;
    logic              sdram_wr_req;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic [LEN_W-1:0]  sdwr_bytes;
    logic [DATA_W-1:0] sdram_wr_data;
    logic              sdram_wr_ack;
    logic              sdram_rd_req;
    logic [ADDR_W-1:0] sdram_rd_addr;
    logic [LEN_W-1:0]  sdrd_bytes;
    logic [DATA_W-1:0] sdram_rd_data;
    logic              sdram_rd_ack;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_len, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_len, p1_wdata,
        input  sdram_init_done, sdram_busy,
        input  sdram_wr_ack, sdram_rd_data, sdram_rd_ack,
        output p0_ack, p0_rdata, p0_done,
        output p1_ack, p1_rdata, p1_done,
        output sdram_wr_req, sdram_wr_addr, sdwr_bytes, sdram_wr_data,
        output sdram_rd_req, sdram_rd_addr, sdrd_bytes
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_len, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_len, p1_wdata,
        output sdram_init_done, sdram_busy,
        output sdram_wr_ack, sdram_rd_data, sdram_rd_ack,
        input  p0_ack, p0_rdata, p0_done,
        input  p1_ack, p1_rdata, p1_done,
        input  sdram_wr_req, sdram_wr_addr, sdwr_bytes, sdram_wr_data,
        input  sdram_rd_req, sdram_rd_addr, sdrd_bytes
    );

endinterface

// File: rtl/sdram_arbiter_rr.sv
// Two-way round-robin picker: rr_ptr breaks the tie when both ports ask.
module sdram_arbiter_rr (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       grant_valid,
    output logic       grant_id
);

    assign grant_valid = |req;
    assign grant_id    = (&req) ? rr_ptr : req[1];

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the sdram_top user port between two burst requesters,
// one burst at a time, round-robin, gated by SDRAM init.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);

    state_t            state, state_n;
    logic              rr_ptr, gnt, lat_we;
    logic [LEN_W-1:0]  lat_len, cnt, cnt_inc;
    logic              grant_valid, grant_id;
    logic              start, active, hit, last;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic              wr_req, rd_req;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [LEN_W-1:0]  wr_len, rd_len;
    logic [1:0]        done_q, rack_q;
    logic [DATA_W-1:0] rdata0, rdata1;

    sdram_arbiter_rr u_rr (
        .req         ({bus.p1_req, bus.p0_req}),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we   = grant_id ? bus.p1_we   : bus.p0_we;
    assign sel_addr = grant_id ? bus.p1_addr : bus.p0_addr;
    assign sel_len  = grant_id ? bus.p1_len  : bus.p0_len;

    assign active  = (state == S_REQ) || (state == S_BURST);
    assign hit     = active && (lat_we ? bus.sdram_wr_ack : bus.sdram_rd_ack);
    assign cnt_inc = cnt + 1'b1;
    assign last    = hit && (cnt_inc == lat_len);
    assign start   = (state == S_IDLE) && bus.sdram_init_done &&
                     !bus.sdram_busy && grant_valid;

    always_comb begin
        state_n = state;
        unique case (state)
            S_INIT:  if (bus.sdram_init_done) state_n = S_IDLE;
            S_IDLE: begin
                if (!bus.sdram_init_done) state_n = S_INIT;
                else if (start)           state_n = S_REQ;
            end
            S_REQ: begin
                if (last)     state_n = S_DONE;
                else if (hit) state_n = S_BURST;
            end
            S_BURST: if (last) state_n = S_DONE;
            S_DONE:  state_n = S_WAIT;
            S_WAIT: begin
                if (!bus.sdram_busy)
                    state_n = bus.sdram_init_done ? S_IDLE : S_INIT;
            end
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_INIT;
            rr_ptr  <= 1'b0;
            gnt     <= 1'b0;
            lat_we  <= 1'b0;
            lat_len <= '0;
            cnt     <= '0;
            wr_req  <= 1'b0;
            rd_req  <= 1'b0;
            wr_addr <= '0;
            rd_addr <= '0;
            wr_len  <= '0;
            rd_len  <= '0;
            done_q  <= '0;
            rack_q  <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state  <= state_n;
            done_q <= '0;
            rack_q <= '0;
            if (start) begin
                gnt     <= grant_id;
                lat_we  <= sel_we;
                lat_len <= fix_len(sel_len);
                cnt     <= '0;
                if (sel_we) begin
                    wr_req  <= 1'b1;
                    wr_addr <= sel_addr;
                    wr_len  <= fix_len(sel_len);
                end else begin
                    rd_req  <= 1'b1;
                    rd_addr <= sel_addr;
                    rd_len  <= fix_len(sel_len);
                end
            end
            // Read words are retimed so ack and rdata line up.
            if (hit) begin
                cnt <= cnt_inc;
                if (!lat_we) begin
                    rack_q[gnt] <= 1'b1;
                    if (gnt) rdata1 <= bus.sdram_rd_data;
                    else     rdata0 <= bus.sdram_rd_data;
                end
            end
            if (last) begin
                wr_req      <= 1'b0;
                rd_req      <= 1'b0;
                done_q[gnt] <= 1'b1;
            end
            if (state == S_DONE) rr_ptr <= ~gnt;
        end
    end

    assign bus.p0_ack   = (hit && lat_we && !gnt) || rack_q[0];
    assign bus.p1_ack   = (hit && lat_we &&  gnt) || rack_q[1];
    assign bus.p0_rdata = rdata0;
    assign bus.p1_rdata = rdata1;
    assign bus.p0_done  = done_q[0];
    assign bus.p1_done  = done_q[1];

    assign bus.sdram_wr_req  = wr_req;
    assign bus.sdram_wr_addr = wr_addr;
    assign bus.sdwr_bytes    = wr_len;
    assign bus.sdram_wr_data = gnt ? bus.p1_wdata : bus.p0_wdata;
    assign bus.sdram_rd_req  = rd_req;
    assign bus.sdram_rd_addr = rd_addr;
    assign bus.sdrd_bytes    = rd_len;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Random two-port traffic against a transaction-level arbiter model.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sdram_arbiter_if bus();

  sdram_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  bit                job   [2];
  bit                jwe   [2];
  logic [ADDR_W-1:0] jaddr [2];
  int                jlen  [2];
  logic [DATA_W-1:0] jdata [2][8];
  int                jk    [2];
  int                jwait [2];
  int                nburst[2];

  bit                bact = 0;
  bit                bwe = 0;
  int                bbytes = 0;
  int                bowner = 0;
  int                issued = 0;
  bit                rd_pend = 0;
  logic [DATA_W-1:0] rd_val = '0;
  bit                last_pend = 0;
  int                last_owner = 0;
  bit                ptr = 0;
  bit                en_new = 0;
  bit                stray_en = 0;
  bit                busy_en = 0;
  bit                init_drv = 0;
  int                ack_pct = 100;
  logic [DATA_W-1:0] rdq[$];

  function automatic int eff(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  task automatic new_job(input int p, input bit we,
                         input logic [ADDR_W-1:0] a, input int l);
    job[p] = 1;
    jwe[p] = we;
    jaddr[p] = a;
    jlen[p] = l;
    jk[p] = 0;
    jwait[p] = 0;
    for (int i = 0; i < 8; i++) jdata[p][i] = DATA_W'($urandom);
  endtask

  task automatic step();
    bit rd_now, last_now, wr_now;
    int lo, o;
    logic [DATA_W-1:0] rv_now, wexp, rdd;
    logic wa, ra;
    @(posedge clock);
    #1;
    rd_now = rd_pend;
    rv_now = rd_val;
    rd_pend = 0;
    last_now = last_pend;
    lo = last_owner;
    last_pend = 0;
    wr_now = 0;
    wexp = '0;
    if (last_now) begin
      bact = 0;
      ptr = (lo == 0);
      job[lo] = 0;
      nburst[lo]++;
    end
    if (!bact && (bus.sdram_wr_req || bus.sdram_rd_req)) begin
      if (bus.p0_req && bus.p1_req) o = int'(ptr);
      else o = bus.p1_req ? 1 : 0;
      chk("grant_req", 32'(bus.p0_req | bus.p1_req), 32'd1);
      chk("dir", 32'(bus.sdram_wr_req), 32'(jwe[o]));
      chk("addr", 32'(jwe[o] ? bus.sdram_wr_addr : bus.sdram_rd_addr),
          32'(jaddr[o]));
      chk("bytes", 32'(jwe[o] ? bus.sdwr_bytes : bus.sdrd_bytes),
          32'(eff(jlen[o])));
      bact = 1;
      bwe = jwe[o];
      bbytes = eff(jlen[o]);
      bowner = o;
      issued = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (job[p]) begin
        jwait[p]++;
        if (jwait[p] > 400) begin
          chk("job_timeout", 32'(jwait[p]), 32'd0);
          job[p] = 0;
        end
      end else if (en_new && $urandom_range(2) == 0) begin
        new_job(p, 1'($urandom_range(1)), ADDR_W'($urandom),
                int'($urandom_range(5)));
      end
    end
    bus.p0_req = job[0];
    bus.p0_we = jwe[0];
    bus.p0_addr = jaddr[0];
    bus.p0_len = LEN_W'(jlen[0]);
    bus.p0_wdata = jdata[0][jk[0] & 7];
    bus.p1_req = job[1];
    bus.p1_we = jwe[1];
    bus.p1_addr = jaddr[1];
    bus.p1_len = LEN_W'(jlen[1]);
    bus.p1_wdata = jdata[1][jk[1] & 7];
    bus.sdram_busy = busy_en && ($urandom_range(3) == 0);
    bus.sdram_init_done = init_drv;
    wa = 0;
    ra = 0;
    rdd = DATA_W'($urandom);
    if (bact && issued < bbytes && int'($urandom_range(99)) < ack_pct) begin
      issued++;
      if (bwe) begin
        wr_now = 1;
        wa = 1;
        wexp = jdata[bowner][jk[bowner] & 7];
      end else begin
        ra = 1;
        if (rdq.size() > 0) rdd = rdq.pop_front();
        rd_pend = 1;
        rd_val = rdd;
      end
      jk[bowner]++;
      if (issued == bbytes) begin
        last_pend = 1;
        last_owner = bowner;
      end
    end
    if (stray_en && $urandom_range(3) == 0) begin
      if (!bact || !bwe) wa = 1;
      if (!bact || bwe) ra = 1;
    end
    bus.sdram_wr_ack = wa;
    bus.sdram_rd_ack = ra;
    bus.sdram_rd_data = rdd;
    @(negedge clock);
    chk("p0_ack", 32'(bus.p0_ack), 32'((wr_now || rd_now) && bowner == 0));
    chk("p1_ack", 32'(bus.p1_ack), 32'((wr_now || rd_now) && bowner == 1));
    if (rd_now)
      chk("rdata", 32'(bowner == 1 ? bus.p1_rdata : bus.p0_rdata),
          32'(rv_now));
    chk("p0_done", 32'(bus.p0_done), 32'(last_now && lo == 0));
    chk("p1_done", 32'(bus.p1_done), 32'(last_now && lo == 1));
    if (wr_now) chk("wr_data", 32'(bus.sdram_wr_data), 32'(wexp));
    if (bact)
      chk("req_hold", 32'({bus.sdram_wr_req, bus.sdram_rd_req}),
          bwe ? 32'd2 : 32'd1);
    else
      chk("req_idle", 32'({bus.sdram_wr_req, bus.sdram_rd_req}), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((job[0] || job[1] || bact) && i < budget) begin
      step();
      i++;
    end
    chk("drain", 32'(job[0] || job[1] || bact), 32'd0);
  endtask

  initial begin
    int nb;
    int i;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0;
    bus.p0_len = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0;
    bus.p1_len = '0; bus.p1_wdata = '0;
    bus.sdram_init_done = 0; bus.sdram_busy = 0;
    bus.sdram_wr_ack = 0; bus.sdram_rd_ack = 0; bus.sdram_rd_data = '0;
    for (int p = 0; p < 2; p++) begin
      job[p] = 0; jwe[p] = 0; jaddr[p] = '0; jlen[p] = 0;
      jk[p] = 0; jwait[p] = 0; nburst[p] = 0;
      for (int w = 0; w < 8; w++) jdata[p][w] = '0;
    end

    repeat (2) step();
    chk("rst_wr_req", 32'(bus.sdram_wr_req), 32'd0);
    chk("rst_rd_req", 32'(bus.sdram_rd_req), 32'd0);
    chk("rst_wr_addr", 32'(bus.sdram_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(bus.sdram_rd_addr), 32'd0);
    chk("rst_wr_len", 32'(bus.sdwr_bytes), 32'd0);
    chk("rst_rd_len", 32'(bus.sdrd_bytes), 32'd0);
    chk("rst_p0_rdata", 32'(bus.p0_rdata), 32'd0);
    chk("rst_p1_rdata", 32'(bus.p1_rdata), 32'd0);
    reset = 0;

    new_job(0, 1, 22'h000100, 4);
    repeat (20) begin
      step();
      chk("init_gate", 32'(bus.sdram_wr_req | bus.sdram_rd_req), 32'd0);
    end
    init_drv = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("init_lat", 32'(bus.sdram_wr_req), 32'(c == 2));
    end
    wait_idle(40);
    chk("wr_burst_cnt", 32'(nburst[0]), 32'd1);

    rdq.push_back(16'hA5A5);
    rdq.push_back(16'h1234);
    rdq.push_back(16'hFFFF);
    new_job(1, 0, 22'h2A5000, 3);
    wait_idle(40);
    chk("rdq_used", 32'(rdq.size()), 32'd0);

    stray_en = 1;
    new_job(0, 0, 22'h012345, 0);
    wait_idle(40);
    new_job(1, 1, 22'h3FFFFF, 0);
    wait_idle(40);

    new_job(0, 1, 22'h000200, 2);
    new_job(1, 0, 22'h000300, 2);
    wait_idle(60);

    en_new = 1;
    busy_en = 1;
    ack_pct = 60;
    repeat (1500) step();
    en_new = 0;
    wait_idle(800);
    chk("p0_seen", 32'(nburst[0] > 10), 32'd1);
    chk("p1_seen", 32'(nburst[1] > 10), 32'd1);

    stray_en = 0;
    busy_en = 0;
    ack_pct = 100;
    nb = nburst[0];
    new_job(0, 1, 22'h3ABCDE, 8);
    i = 0;
    while (!(bact && issued == 2) && i < 40) begin
      step();
      i++;
    end
    chk("rst_reach", 32'(issued), 32'd2);
    #2;
    reset = 1;
    #1;
    chk("mid_wr_req", 32'(bus.sdram_wr_req), 32'd0);
    chk("mid_p0_ack", 32'(bus.p0_ack), 32'd0);
    chk("mid_p0_done", 32'(bus.p0_done), 32'd0);
    chk("mid_wr_addr", 32'(bus.sdram_wr_addr), 32'd0);
    chk("mid_wr_len", 32'(bus.sdwr_bytes), 32'd0);
    bact = 0;
    issued = 0;
    rd_pend = 0;
    last_pend = 0;
    ptr = 0;
    jk[0] = 0;
    init_drv = 0;
    bus.sdram_wr_ack = 0;
    bus.sdram_rd_ack = 0;
    repeat (3) step();
    reset = 0;
    repeat (3) begin
      step();
      chk("rst_gate", 32'(bus.sdram_wr_req | bus.sdram_rd_req), 32'd0);
    end
    init_drv = 1;
    wait_idle(60);
    chk("rst_new_burst", 32'(nburst[0]), 32'(nb + 1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-port burst arbiter that shares the single user interface of sdram_top between two requesters. Port 0 is the display/segment path; port 1 is the CPU/test path.
- Sits between the requesters and sdram_top. It holds off all traffic until sdram_init_done, grants round-robin, and drives one read or write burst at a time.
- It counts per-word acks to detect burst end, then signals completion to the owning requester.

Parameters:
- ADDR_W, 22, SDRAM word address width ({bank, row, col}).
- DATA_W, 16, SDRAM data width.
- LEN_W, 9, burst length width in words (1..256).

Ports:
- clock  in  1  system clock (50 MHz domain of sdram_top).
- reset  in  1  asynchronous, active-high reset.
- pN_req  in  1  port N (N=0,1) burst request; held until pN_done.
- pN_we  in  1  1=write burst, 0=read burst.
- pN_addr  in  ADDR_W  burst start address.
- pN_len  in  LEN_W  burst length in words.
- pN_wdata  in  DATA_W  write word; must be valid whenever pN_ack can fire.
- pN_ack  out  1  one word transferred for port N this cycle.
- pN_rdata  out  DATA_W  read word, valid when pN_ack && !pN_we.
- pN_done  out  1  one-cycle pulse: port N burst finished.
- sdram_init_done  in  1  from sdram_top.
- sdram_busy  in  1  from sdram_top.
- sdram_wr_req  out  1  write burst request.
- sdram_wr_addr  out  ADDR_W  write start address.
- sdwr_bytes  out  LEN_W  write burst length.
- sdram_wr_data  out  DATA_W  write word.
- sdram_wr_ack  in  1  per-word write ack.
- sdram_rd_req  out  1  read burst request.
- sdram_rd_addr  out  ADDR_W  read start address.
- sdrd_bytes  out  LEN_W  read burst length.
- sdram_rd_data  in  DATA_W  read word.
- sdram_rd_ack  in  1  per-word read ack / read data valid.

Behaviour:
- Reset: all registered outputs are 0 (reqs, addrs, lengths, done, ack, rdata). State is INIT, rr_ptr is 0, word counter is 0.
- INIT: wait for sdram_init_done=1, then go to IDLE. No grants are issued before this.
- IDLE: if any pN_req is high and sdram_busy=0, pick the winner and latch its we/addr/len. len=0 is coerced to 1. Go to REQ.
- Arbitration, both requesting: the port equal to rr_ptr wins.
- Arbitration, one requesting: that port wins.
- REQ: assert sdram_wr_req or sdram_rd_req with the latched addr/len. The req is registered, so it goes high 1 cycle after the IDLE decision.
- REQ is held until the first ack. Then go to BURST. The first ack counts as word 1.
- BURST: each ack of the active direction increments the counter and pulses the granted pN_ack in the same cycle (combinational pass-through).
- sdram_wr_data is combinationally muxed from the granted port's pN_wdata.
- pN_rdata is registered from sdram_rd_data when sdram_rd_ack=1, and is valid in the cycle after the ack. pN_ack for reads is therefore also registered (aligned with rdata). The write ack stays combinational.
- sdram_*_req drops in the cycle after the final ack (count == latched len).
- DONE: pulse pN_done for 1 cycle, set rr_ptr = ~granted, go to WAIT.
- WAIT: stay until sdram_busy=0, then go to IDLE. The minimum gap between bursts is 2 cycles.
- Acks of the inactive direction, or acks in INIT/IDLE/WAIT, are ignored and never forwarded.
- If pN_req drops mid-burst, the burst still runs to completion and pN_done still pulses.
- If a requester re-asserts pN_req in the cycle after done, the other port still wins if it is requesting (fairness).
- The non-granted port never sees ack or done.
- Reset mid-burst: all outputs are cleared asynchronously and state returns to INIT. sdram_top is reset on the same net (inverted to rst_n).
- If sdram_init_done falls at any time, return to INIT after the current burst ends.

Decomposition:
- Shared header sdram_arb_defs.vh holds:
  - state encodings: INIT, IDLE, REQ, BURST, DONE, WAIT;
  - default ADDR_W, DATA_W, LEN_W.
- One sub-module, sdram_arb_rr: 2-way round-robin picker.
  - Inputs: req[1:0], rr_ptr.
  - Outputs: grant_valid, grant_id.
  - Purely combinational.

Test Plan:
- Init gating: p0_req=1 while sdram_init_done=0 for 20 cycles -> no sdram_wr_req/sdram_rd_req; the req rises 2 cycles after init_done rises.
- Single write: p0 we=1, addr=0x000100, len=4, model acks on 4 consecutive cycles -> sdwr_bytes=4, 4 p0_ack pulses, p0_done one cycle after the 4th ack, p1 signals quiet.
- Round-robin: p0 and p1 request simultaneously and continuously, len=2 -> grant order p0, p1, p0, p1; each done pulses exactly once per burst.
- Read data path: p1 we=0, len=3, model returns 0xA5A5, 0x1234, 0xFFFF -> p1_rdata presents those values in order, each with p1_ack one cycle after its sdram_rd_ack.
- Edge cases: len=0 -> sdrd_bytes=1, done after 1 ack; a stray sdram_wr_ack during a read burst -> counter unchanged, no p_ack.
- Reset mid-burst: reset asserted after 2 of 8 acks -> all outputs 0 immediately, state INIT; after release and init_done, a new request completes normally.
